// File: rtl/clk_pkg.sv
// Shared clock constants and helpers for consumers of the core's divided clocks.
package clk_pkg;

    localparam int unsigned CLK_74_HZ = 74_000_000;

    // A divider toggling every term_count cycles produces a period of twice that.
    function automatic int unsigned expected_period(input int unsigned term_count);
        return 2 * term_count;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into clk_74 and emits one-cycle rise/fall pulses.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_74,
    input  logic reset_n,
    input  logic d_async,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;

    always_ff @(posedge clk_74 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_async};
            level_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_q;
    assign fall  = ~level & level_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow clock in clk_74 cycles, with stall and lock status.
module clock_period_meter
    import clk_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = CLK_74_HZ,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic             clk_74,
    input  logic             reset_n,
    input  logic             clk_in,
    input  logic             enable,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitRise = 2'd1,
        StMeasure  = 2'd2,
        StStalled  = 2'd3
    } state_e;

    localparam int unsigned          StreakW     = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0]     TimeoutLast = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0]     TimeoutMax  = WIDTH'(TIMEOUT);
    localparam logic [StreakW-1:0]   LockMax     = StreakW'(LOCK_COUNT);

    logic clk_level, rise_evt, fall_evt;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_74  (clk_74),
        .reset_n (reset_n),
        .d_async (clk_in),
        .level   (clk_level),
        .rise    (rise_evt),
        .fall    (fall_evt)
    );

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic [WIDTH-1:0]   high_q, high_d;
    logic [StreakW-1:0] streak_q, streak_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    logic [WIDTH-1:0] cnt_plus1;
    logic             cnt_at_limit;

    assign cnt_plus1    = cnt_q + WIDTH'(1);
    assign cnt_at_limit = (cnt_q == TimeoutLast);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        period_d  = period_q;
        high_d    = high_q;
        streak_d  = streak_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;

        if (rise_evt) begin
            cnt_d = '0;
        end else if (cnt_q != TimeoutMax) begin
            cnt_d = cnt_plus1;
        end else begin
            cnt_d = cnt_q;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                streak_d  = '0;
                locked_d  = 1'b0;
                timeout_d = 1'b0;
                state_d   = StWaitRise;
            end
            StWaitRise: begin
                if (rise_evt) begin
                    state_d = StMeasure;
                end else if (cnt_at_limit) begin
                    state_d   = StStalled;
                    timeout_d = 1'b1;
                end
            end
            StMeasure: begin
                if (fall_evt && !clk_level) begin
                    hold_d = cnt_plus1;
                end
                if (rise_evt) begin
                    period_d = cnt_plus1;
                    high_d   = hold_q;
                    valid_d  = 1'b1;
                    // Streak of 0 means this is the first period since (re)entering MEASURE.
                    if (streak_q == '0 || cnt_plus1 != period_q) begin
                        streak_d = StreakW'(1);
                    end else if (streak_q != LockMax) begin
                        streak_d = streak_q + StreakW'(1);
                    end
                    locked_d = (streak_d >= LockMax);
                end else if (cnt_at_limit) begin
                    state_d   = StStalled;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    streak_d  = '0;
                end
            end
            StStalled: begin
                if (rise_evt) begin
                    state_d   = StMeasure;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Disabling overrides everything, including a coincident rising edge.
        if (!enable) begin
            state_d   = StIdle;
            cnt_d     = '0;
            streak_d  = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_74 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hold_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            streak_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            period_q  <= period_d;
            high_q    <= high_d;
            streak_q  <= streak_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: directed clk_in waveforms with hand-computed results.
`timescale 1ns/100ps
module tb_clock_period_meter;
    import clk_pkg::*;

    localparam int unsigned Width = 32;

    logic             clk_74 = 1'b0;
    logic             reset_n = 1'b0;
    logic             clk_in = 1'b0;
    logic             enable = 1'b1;
    logic [Width-1:0] period, high_time;
    logic             valid, locked, timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rng;
        logic [31:0] p;
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    clock_period_meter #(
        .WIDTH      (Width),
        .SYNC_STAGES(2),
        .TIMEOUT    (100),
        .LOCK_COUNT (4)
    ) dut (
        .clk_74   (clk_74),
        .reset_n  (reset_n),
        .clk_in   (clk_in),
        .enable   (enable),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .locked   (locked),
        .timeout  (timeout)
    );

    always #5 clk_74 = ~clk_74;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk_74) begin
        if (reset_n && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got period=%0d high=%0d expected no valid at %0t",
                         period, high_time, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.rng) begin
                    checks++;
                    if (!((period == 20 || period == 21) &&
                          (2 * high_time + 2 >= period) && (2 * high_time <= period + 2))) begin
                        errors++;
                        $display("FAIL async_meas got period=%0d high=%0d expected 20..21, half+-1",
                                 period, high_time);
                    end
                end else begin
                    chk("valid_period", period, mon_e.p);
                    chk("valid_high_time", high_time, mon_e.h);
                    chk("valid_locked", {31'd0, locked}, mon_e.l);
                end
            end
        end
    end

    // One clk_in cycle starting with a rise at a negedge; optionally expects the valid that
    // this rise produces for the interval it closes.
    task automatic cyc(input int h, input int l, input bit push, input int ep, input int eh,
                       input bit el);
        @(negedge clk_74);
        clk_in = 1'b1;
        if (push) exp_q.push_back('{rng: 1'b0, p: ep, h: eh, l: {31'd0, el}});
        repeat (h) @(negedge clk_74);
        clk_in = 1'b0;
        repeat (l - 1) @(negedge clk_74);
    endtask

    int ep10;

    initial begin
        ep10 = int'(expected_period(5));

        // Reset state
        #12;
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        @(negedge clk_74);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_74);

        // Divider with terminal count 5: lock on the 4th valid
        cyc(5, 5, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) cyc(5, 5, 1, ep10, 5, k >= 4);

        // One 12-cycle interval breaks lock; four 10s restore it
        cyc(6, 6, 1, ep10, 5, 1);
        cyc(5, 5, 1, 12, 6, 0);
        for (int k = 1; k <= 4; k++) cyc(5, 5, 1, ep10, 5, k >= 4);

        // Stall: rise at N0 is consumed at posedge 2; timeout visible 100 cycles later
        @(negedge clk_74);
        clk_in = 1'b1;
        exp_q.push_back('{rng: 1'b0, p: ep10, h: 5, l: 1});
        repeat (5) @(negedge clk_74);
        clk_in = 1'b0;
        repeat (97) @(negedge clk_74);
        chk("timeout_early", {31'd0, timeout}, 0);
        chk("locked_before_stall", {31'd0, locked}, 1);
        @(negedge clk_74);
        chk("timeout_set", {31'd0, timeout}, 1);
        chk("stall_locked", {31'd0, locked}, 0);
        chk("stall_period_held", period, ep10);

        // Next rise clears timeout without a valid
        @(negedge clk_74);
        clk_in = 1'b1;
        repeat (2) @(negedge clk_74);
        chk("timeout_still_set", {31'd0, timeout}, 1);
        @(negedge clk_74);
        chk("timeout_cleared", {31'd0, timeout}, 0);
        repeat (2) @(negedge clk_74);
        clk_in = 1'b0;
        repeat (4) @(negedge clk_74);
        for (int k = 1; k <= 4; k++) cyc(5, 5, 1, ep10, 5, k >= 4);

        // enable drops in the same cycle the rise event is consumed
        @(negedge clk_74);
        clk_in = 1'b1;
        repeat (2) @(negedge clk_74);
        enable = 1'b0;
        @(negedge clk_74);
        chk("disable_locked", {31'd0, locked}, 0);
        chk("disable_period_held", period, ep10);
        chk("disable_high_held", high_time, 5);
        repeat (2) @(negedge clk_74);
        clk_in = 1'b0;
        repeat (5) @(negedge clk_74);
        enable = 1'b1;
        repeat (4) @(negedge clk_74);
        cyc(5, 5, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) cyc(5, 5, 1, ep10, 5, 0);
        @(negedge clk_74);
        clk_in = 1'b1;
        exp_q.push_back('{rng: 1'b0, p: ep10, h: 5, l: 1});

        // Asynchronous reset mid-period
        repeat (5) @(negedge clk_74);
        clk_in = 1'b0;
        repeat (2) @(negedge clk_74);
        reset_n = 1'b0;
        #1;
        chk("arst_period", period, 0);
        chk("arst_high_time", high_time, 0);
        chk("arst_locked", {31'd0, locked}, 0);
        chk("arst_timeout", {31'd0, timeout}, 0);
        chk("arst_valid", {31'd0, valid}, 0);
        repeat (3) @(negedge clk_74);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_74);
        cyc(5, 5, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) cyc(5, 5, 1, ep10, 5, k >= 4);

        // Free-running clk_in at 20.3 clk_74 cycles
        @(negedge clk_74);
        enable = 1'b0;
        repeat (3) @(negedge clk_74);
        enable = 1'b1;
        @(negedge clk_74);
        #3.7;
        for (int i = 0; i < 16; i++) begin
            clk_in = 1'b1;
            if (i > 0) exp_q.push_back('{rng: 1'b1, p: 0, h: 0, l: 0});
            #101.5;
            clk_in = 1'b0;
            #101.5;
        end
        @(negedge clk_74);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_74);
        chk("pending_expectations", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures an incoming slow clock or tick signal (e.g. a divided-down clock from elsewhere in the core) in units of clk_74 cycles. It reports full period and high time, flags a stalled input, and declares lock once the period is stable. It sits on the consuming side of the core's clock-divider outputs and is used for self-check and status readback.

## Interface
- WIDTH, 32: width of counters and measurement outputs.
- SYNC_STAGES, 2: synchronizer flops on clk_in (minimum 2).
- TIMEOUT, 74000000: clk_74 cycles without a rising edge before declaring a stall. Must be < 2^WIDTH.
- LOCK_COUNT, 4: consecutive identical periods required for lock (≥ 2).

- clk_74  in  1  system clock, 74 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- clk_in  in  1  measured signal, asynchronous to clk_74.
- enable  in  1  measurement enable; low forces IDLE.
- period  out  WIDTH  clk_74 cycles between the last two rising edges.
- high_time  out  WIDTH  clk_74 cycles from the last rising edge to the following falling edge.
- valid  out  1  one-cycle pulse when period/high_time update.
- locked  out  1  period stable for LOCK_COUNT consecutive measurements.
- timeout  out  1  stall flag. Sticky until the next rising edge or until enable goes low.

## Operation
- Sub-block syncs clk_in through SYNC_STAGES flops. It produces rise_evt / fall_evt as 1-cycle pulses by comparing the synchronized value with a one-cycle-delayed copy.
- cnt: WIDTH-bit counter of cycles since the last rise_evt. It clears to 0 on rise_evt, increments otherwise, and saturates at TIMEOUT.
- States:
  - IDLE: enable low. cnt=0, lock streak=0, locked=0, timeout=0. enable high → WAIT_RISE.
  - WAIT_RISE: ignore fall_evt. rise_evt → MEASURE with cnt cleared. cnt reaches TIMEOUT-1 → STALLED.
  - MEASURE:
    - fall_evt: hold_high <= cnt+1.
    - rise_evt: period <= cnt+1, high_time <= hold_high, valid=1, cnt cleared.
    - If the new period equals the previous period, the streak increments, saturating at LOCK_COUNT. Otherwise the streak resets to 1.
    - locked = (streak ≥ LOCK_COUNT). The first period after entering MEASURE starts the streak at 1.
    - cnt reaches TIMEOUT-1 → STALLED.
  - STALLED: timeout=1, locked=0, streak=0, no valid. rise_evt → MEASURE (timeout clears, cnt cleared, no period output for the partial interval).
- enable low in any state → IDLE next cycle. enable low wins over a simultaneous rise_evt.
- period and high_time hold their last value through STALLED and IDLE. Only valid marks new data.
- If no fall_evt occurs between two rises, high_time reports the stale hold_high. This cannot happen for a clean clock; it is documented, not flagged.
- Reset mid-measurement: all state and outputs return to reset values immediately (asynchronous). The first post-reset rise_evt only starts a measurement.

## Timing
- Reset values: period=0, high_time=0, valid=0, locked=0, timeout=0. State = IDLE.
- Input latency: a clk_in edge to rise_evt/fall_evt takes SYNC_STAGES+1 clk_74 edges (3 by default), ±1 cycle of sampling uncertainty.
- valid is asserted the cycle after rise_evt, together with the updated period/high_time. locked updates in the same cycle as valid.
- timeout asserts the cycle after cnt reaches TIMEOUT-1, i.e. TIMEOUT cycles after the last rise_evt (or after entering WAIT_RISE).
- Arithmetic: cnt+1 computed at WIDTH bits; no overflow given TIMEOUT < 2^WIDTH. Equality compare is on full WIDTH.

## Structure
- Sub-module sync_edge_detect (parameter SYNC_STAGES; ports clk_74, reset_n, d_async, level, rise, fall). It is reusable for other async inputs.
- State encoding as localparams inside clock_period_meter.
- Shared package clk_pkg holds CLK_74_HZ = 74000000 for computing TIMEOUT and expected period constants. It also holds the expected-period helper: expected period = 2 × divider terminal count.
- No other sub-modules.

## Test plan
- clk_in from a divider with terminal count 5 (toggle every 5 clk_74 cycles), enable=1 → period=10, high_time=5, valid every 10 cycles, locked=1 on the 4th valid.
- Same input with an irregular period of 12 cycles on one interval → that valid reports period=12, locked drops to 0, and locked returns after 4 more periods of 10.
- TIMEOUT=100, clk_in held low after locking → timeout=1 and locked=0 exactly 100 cycles after the last rise_evt. The next rising edge clears timeout with no valid, and the edge after that gives valid with the correct period.
- enable deasserted in the same cycle as rise_evt → IDLE, no valid, locked=0. Re-enable → first valid appears only after two rises.
- reset_n pulsed low mid-period → all outputs 0 immediately, then normal measurement resumes after reset.
- Fully asynchronous clk_in (period 20.3 clk_74 cycles) → each reported period is 20 or 21, and high_time stays within ±1 of half the period.
